xvc_timeout_scheduler: RTL

Multi-slot millisecond timeout scheduler for the XVC microserver. Derives a 1 ms tick from the system clock. Lets software-side requesters arm or cancel up to NUM_SLOTS independent timeouts through one command port. Delivers expiry events one at a time through a valid/ready port, with round-robin arbitration among expired slots.

---
 rtl/xvc_timer_pkg.sv | 18 +
 rtl/xvc_ms_tick_gen.sv | 33 +++
 rtl/xvc_timeout_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/xvc_timer_pkg.sv
// rtl/xvc_timer_pkg.sv - shared types and defaults for the XVC timeout scheduler
package xvc_timer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    EXPIRED   = 2'd2,
    PRESENTED = 2'd3
  } slot_state_e;

  typedef enum logic {
    CMD_ARM    = 1'b0,
    CMD_CANCEL = 1'b1
  } cmd_op_e;

  localparam int XVC_CLOCK_RATIO_DEFAULT = 200000;

endpackage

// File: rtl/xvc_ms_tick_gen.sv
// rtl/xvc_ms_tick_gen.sv - clock prescaler producing a 1 ms tick and a free-running ms counter
module xvc_ms_tick_gen
  import xvc_timer_pkg::*;
#(
  parameter int CLOCK_RATIO = XVC_CLOCK_RATIO_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic        tick,
  output logic [31:0] now_ms
);

  // A ratio of 1 still needs a one-bit counter that sits at 0 and ticks every cycle.
  localparam int CNT_W = (CLOCK_RATIO > 1) ? $clog2(CLOCK_RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLOCK_RATIO - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= '0;
      now_ms <= '0;
    end else if (tick) begin
      count  <= '0;
      now_ms <= now_ms + 32'd1;
    end else begin
      count  <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/xvc_timeout_scheduler.sv
// rtl/xvc_timeout_scheduler.sv - multi-slot ms timeout scheduler with round-robin expiry delivery
// Optional XVC_TIMEOUT_STATS_EN adds the exp_count handshake counter.
module xvc_timeout_scheduler
  import xvc_timer_pkg::*;
#(
  parameter int CLOCK_RATIO = XVC_CLOCK_RATIO_DEFAULT,
  parameter int NUM_SLOTS   = 4,
  parameter int TIMEOUT_W   = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_op,
  input  logic [$clog2(NUM_SLOTS)-1:0] cmd_slot,
  input  logic [TIMEOUT_W-1:0]         cmd_timeout_ms,
  output logic                         exp_valid,
  input  logic                         exp_ready,
  output logic [$clog2(NUM_SLOTS)-1:0] exp_slot,
  output logic [NUM_SLOTS-1:0]         slot_active,
  output logic [31:0]                  now_ms
`ifdef XVC_TIMEOUT_STATS_EN
  ,
  output logic [31:0]                  exp_count
`endif
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);

  logic                 tick;
  slot_state_e          state_q  [NUM_SLOTS];
  slot_state_e          state_d  [NUM_SLOTS];
  logic [TIMEOUT_W-1:0] remain_q [NUM_SLOTS];
  logic [TIMEOUT_W-1:0] remain_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] cand;
  logic [SLOT_W-1:0]    rr_q;
  logic [SLOT_W-1:0]    grant_idx;
  logic [SLOT_W-1:0]    slot_q;
  logic                 grant_found;
  logic                 load;
  logic                 cmd_fire;
  logic                 hs;
  logic                 ready_q;
  logic                 valid_q;

  xvc_ms_tick_gen #(
    .CLOCK_RATIO(CLOCK_RATIO)
  ) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .tick  (tick),
    .now_ms(now_ms)
  );

  function automatic logic [SLOT_W-1:0] rr_index(input logic [SLOT_W-1:0] base, input int offset);
    int s;
    s = int'(base) + offset;
    if (s >= NUM_SLOTS) s = s - NUM_SLOTS;
    return SLOT_W'(s);
  endfunction

  assign cmd_ready = ready_q;
  assign exp_valid = valid_q;
  assign exp_slot  = slot_q;
  assign cmd_fire  = cmd_valid && ready_q;
  assign hs        = valid_q && exp_ready;

  // A slot targeted by this cycle's command is withheld from arbitration: the command wins.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cand[i] = (state_q[i] == EXPIRED) && !(cmd_fire && (cmd_slot == SLOT_W'(i)));
    end
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (cand[rr_index(rr_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = rr_index(rr_q, k);
      end
    end
    load = grant_found && (!valid_q || hs);
  end

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      state_d[i]  = state_q[i];
      remain_d[i] = remain_q[i];
      if (cmd_fire && (cmd_slot == SLOT_W'(i))) begin
        if (cmd_op == CMD_CANCEL) begin
          state_d[i]  = IDLE;
          remain_d[i] = '0;
        end else if (cmd_timeout_ms == '0) begin
          state_d[i]  = EXPIRED;
          remain_d[i] = '0;
        end else begin
          state_d[i]  = ARMED;
          remain_d[i] = cmd_timeout_ms;
        end
      end else begin
        if (tick && (state_q[i] == ARMED)) begin
          if (remain_q[i] <= TIMEOUT_W'(1)) begin
            state_d[i]  = EXPIRED;
            remain_d[i] = '0;
          end else begin
            remain_d[i] = remain_q[i] - TIMEOUT_W'(1);
          end
        end
        if (hs && (slot_q == SLOT_W'(i)) && (state_q[i] == PRESENTED)) begin
          state_d[i] = IDLE;
        end
        if (load && (grant_idx == SLOT_W'(i))) begin
          state_d[i] = PRESENTED;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i]  <= IDLE;
        remain_q[i] <= '0;
      end
      rr_q    <= '0;
      valid_q <= 1'b0;
      slot_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i]  <= state_d[i];
        remain_q[i] <= remain_d[i];
      end
      ready_q <= 1'b1;
      if (load) begin
        valid_q <= 1'b1;
        slot_q  <= grant_idx;
        rr_q    <= rr_index(grant_idx, 1);
      end else if (hs) begin
        valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    slot_active = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_active[i] = (state_q[i] != IDLE);
    end
  end

`ifdef XVC_TIMEOUT_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      exp_count <= '0;
    end else if (hs) begin
      exp_count <= exp_count + 32'd1;
    end
  end
`endif

endmodule
